// File: rtl/dual_edge_gen_if.sv
// Request/level bus between a dual-edge generator and its user.
// EDGE_GEN_STICKY_DROP_EN adds the drop_clr / drop_sticky pair.
interface dual_edge_gen_if #(
    parameter int unsigned PEND_W = 3
) ();
    logic              req;
    logic              sig;
    logic              busy;
    logic [PEND_W-1:0] pending;
    logic              drop;
`ifdef EDGE_GEN_STICKY_DROP_EN
    logic              drop_clr;
    logic              drop_sticky;

    modport master (output req, output drop_clr,
                    input sig, input busy, input pending, input drop, input drop_sticky);
    modport slave  (input req, input drop_clr,
                    output sig, output busy, output pending, output drop, output drop_sticky);
`else
    modport master (output req, input sig, input busy, input pending, input drop);
    modport slave  (input req, output sig, output busy, output pending, output drop);
`endif
endinterface

// File: rtl/dual_edge_gen.sv
// Turns request pulses into spaced transitions on a level output, queueing bursts.
// Optional feature macro: EDGE_GEN_STICKY_DROP_EN (sticky drop flag with clear input).
module dual_edge_gen #(
    parameter int unsigned MIN_HOLD = 4,
    parameter int unsigned PEND_W   = 3,
    parameter int unsigned INIT_LVL = 0
) (
    input  logic            clk,
    input  logic            reset,
    dual_edge_gen_if.slave  bus
);
    localparam int unsigned HOLD_W = (MIN_HOLD > 1) ? $clog2(MIN_HOLD) : 1;
    localparam int unsigned DW     = PEND_W + 1;
    localparam logic [DW-1:0] PEND_MAX = DW'((1 << PEND_W) - 1);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t            state_q, state_nx;
    logic [HOLD_W-1:0] hold_q, hold_nx;
    logic [PEND_W-1:0] pend_q, pend_sat;
    logic              sig_q, sig_nx;
    logic              busy_q, busy_nx;
    logic              drop_q, drop_nx;
    logic [DW-1:0]     demand, pend_nx;
    logic              eligible, fire;

    // State register: every flop shares the synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            hold_q  <= '0;
            pend_q  <= '0;
            sig_q   <= 1'(INIT_LVL);
            busy_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_nx;
            hold_q  <= hold_nx;
            pend_q  <= pend_sat;
            sig_q   <= sig_nx;
            busy_q  <= busy_nx;
            drop_q  <= drop_nx;
        end
    end

    // Next state: an edge may only be emitted once the hold window has expired
    always_comb begin
        demand   = DW'(pend_q) + DW'(bus.req);
        eligible = (state_q == IDLE) || (hold_q == '0);
        fire     = eligible && (demand != '0);
        state_nx = state_q;
        if (fire) begin
            state_nx = HOLD;
        end else if (eligible) begin
            state_nx = IDLE;
        end
    end

    // Outputs: consumption and new request net out before saturation
    always_comb begin
        sig_nx  = sig_q;
        hold_nx = hold_q;
        pend_nx = demand;
        if (fire) begin
            sig_nx  = ~sig_q;
            hold_nx = HOLD_W'(MIN_HOLD - 1);
            pend_nx = demand - DW'(1);
        end else if (eligible) begin
            pend_nx = '0;
        end else begin
            hold_nx = hold_q - HOLD_W'(1);
        end
        drop_nx  = (pend_nx > PEND_MAX);
        pend_sat = drop_nx ? PEND_MAX[PEND_W-1:0] : pend_nx[PEND_W-1:0];
        busy_nx  = (state_nx == HOLD) || (pend_sat != '0);
    end

    assign bus.sig     = sig_q;
    assign bus.busy    = busy_q;
    assign bus.pending = pend_q;
    assign bus.drop    = drop_q;

`ifdef EDGE_GEN_STICKY_DROP_EN
    logic sticky_q;

    // A drop in the same cycle as a clear keeps the flag set
    always_ff @(posedge clk) begin
        if (reset) begin
            sticky_q <= 1'b0;
        end else if (drop_nx) begin
            sticky_q <= 1'b1;
        end else if (bus.drop_clr) begin
            sticky_q <= 1'b0;
        end
    end

    assign bus.drop_sticky = sticky_q;
`endif
endmodule

// File: tb/tb_dual_edge_gen.sv
// Scoreboard bench for dual_edge_gen: two instances (MIN_HOLD=4/INIT 0, MIN_HOLD=1/INIT 1).
module tb_dual_edge_gen;
    localparam int unsigned PW   = 2;
    localparam int          PMAX = 3;

    typedef struct packed {
        logic          sig;
        logic          busy;
        logic [PW-1:0] pending;
        logic          drop;
`ifdef EDGE_GEN_STICKY_DROP_EN
        logic          sticky;
`endif
    } obs_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic req = 1'b0;
    logic drop_clr = 1'b0;

    int checks = 0;
    int errors = 0;

    obs_t q0[$];
    obs_t q1[$];

    int m_lvl[2];
    int m_pend[2];
    int m_last[2];
    int m_sticky[2];
    int m_cyc = 0;
    int m_drops0 = 0;

    int ev0 = 0;
    int dr0 = 0;
    int dr1 = 0;
    logic prev0 = 1'b0;

    dual_edge_gen_if #(.PEND_W(PW)) if0 ();
    dual_edge_gen_if #(.PEND_W(PW)) if1 ();

    assign if0.req = req;
    assign if1.req = req;
`ifdef EDGE_GEN_STICKY_DROP_EN
    assign if0.drop_clr = drop_clr;
    assign if1.drop_clr = drop_clr;
`endif

    dual_edge_gen #(.MIN_HOLD(4), .PEND_W(PW), .INIT_LVL(0)) dut0 (
        .clk(clk), .reset(reset), .bus(if0.slave));
    dual_edge_gen #(.MIN_HOLD(1), .PEND_W(PW), .INIT_LVL(1)) dut1 (
        .clk(clk), .reset(reset), .bus(if1.slave));

    always #5 clk = ~clk;

    function automatic int mh(input int k);
        return (k == 0) ? 4 : 1;
    endfunction

    function automatic int init_lvl(input int k);
        return (k == 0) ? 0 : 1;
    endfunction

    // Reference: edges allowed once MIN_HOLD cycles have passed since the last edge
    task automatic model_step(input int k, input bit rst, input bit rq, input bit clr,
                              output obs_t e);
        int demand;
        int nx;
        bit elig;
        bit drp;
        e = '0;
        if (rst) begin
            m_lvl[k]    = init_lvl(k);
            m_pend[k]   = 0;
            m_last[k]   = -1000;
            m_sticky[k] = 0;
        end else begin
            elig   = (m_cyc - m_last[k]) >= mh(k);
            demand = m_pend[k] + int'(rq);
            if (elig && demand > 0) begin
                m_lvl[k]  = 1 - m_lvl[k];
                m_last[k] = m_cyc;
                nx        = demand - 1;
            end else if (elig) begin
                nx = 0;
            end else begin
                nx = demand;
            end
            drp       = nx > PMAX;
            m_pend[k] = drp ? PMAX : nx;
            if (drp) m_sticky[k] = 1;
            else if (clr) m_sticky[k] = 0;
            e.drop = drp;
            e.busy = ((m_cyc - m_last[k]) < mh(k)) || (m_pend[k] != 0);
        end
        e.sig     = (m_lvl[k] != 0);
        e.pending = PW'(m_pend[k]);
`ifdef EDGE_GEN_STICKY_DROP_EN
        e.sticky  = (m_sticky[k] != 0);
`endif
    endtask

    // One clock of stimulus; expectations for both instances go to the scoreboard
    task automatic cyc(input bit rst, input bit rq, input bit clr);
        obs_t e;
        @(negedge clk);
        reset    = rst;
        req      = rq;
        drop_clr = clr;
        model_step(0, rst, rq, clr, e);
        q0.push_back(e);
        if (e.drop) m_drops0++;
        model_step(1, rst, rq, clr, e);
        q1.push_back(e);
        m_cyc++;
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_obs(input string n, input obs_t g, input obs_t e);
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL %s cyc~%0d got %b exp %b (sig,busy,pending,drop[,sticky])",
                     n, m_cyc, g, e);
        end
    endtask

    task automatic chk_val(input string n, input int g, input int e);
        checks++;
        if (g != e) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", n, g, e);
        end
    endtask

    // Monitor: pops one expectation per instance per clock, plus a dual-edge detector on dut0
    initial begin
        obs_t e;
        obs_t g;
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0) begin
                e = q0.pop_front();
                g = '0;
                g.sig = if0.sig; g.busy = if0.busy; g.pending = if0.pending; g.drop = if0.drop;
`ifdef EDGE_GEN_STICKY_DROP_EN
                g.sticky = if0.drop_sticky;
`endif
                chk_obs("dut0", g, e);
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                g = '0;
                g.sig = if1.sig; g.busy = if1.busy; g.pending = if1.pending; g.drop = if1.drop;
`ifdef EDGE_GEN_STICKY_DROP_EN
                g.sticky = if1.drop_sticky;
`endif
                chk_obs("dut1", g, e);
            end
            if (if0.sig !== prev0) ev0++;
            prev0 = if0.sig;
            if (if0.drop === 1'b1) dr0++;
            if (if1.drop === 1'b1) dr1++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int ev_s;
        int dr_s;
        int md_s;
        int reqs;
        bit rq;
        bit clr;

        // Reset held three cycles
        repeat (3) cyc(1'b1, 1'b0, 1'b0);
        settle();
        chk_val("rst_sig0", int'(if0.sig), 0);
        chk_val("rst_sig1_init1", int'(if1.sig), 1);
        chk_val("rst_busy", int'(if0.busy), 0);
        chk_val("rst_pending", int'(if0.pending), 0);

        // Single request, then a second inside the hold window
        repeat (10) cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        settle();
        chk_val("t2_pending1", int'(if0.pending), 1);
        repeat (5) cyc(1'b0, 1'b0, 1'b0);
        settle();
        chk_val("t2_busy_c18", int'(if0.busy), 1);
        chk_val("t2_sig_low", int'(if0.sig), 0);
        cyc(1'b0, 1'b0, 1'b0);
        settle();
        chk_val("t2_busy_c19", int'(if0.busy), 0);

        // Six back-to-back requests: one overflow, five spaced edges
        cyc(1'b1, 1'b0, 1'b0);
        settle();
        ev_s = ev0;
        dr_s = dr0;
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, (i == 5));
        repeat (14) cyc(1'b0, 1'b0, 1'b0);
        settle();
        chk_val("t3_edges", ev0 - ev_s, 5);
        chk_val("t3_drops", dr0 - dr_s, 1);
        chk_val("t3_final_sig", int'(if0.sig), 1);
        chk_val("t3_pending0", int'(if0.pending), 0);
`ifdef EDGE_GEN_STICKY_DROP_EN
        chk_val("t3_sticky_held", int'(if0.drop_sticky), 1);
        cyc(1'b0, 1'b0, 1'b1);
        settle();
        chk_val("t3_sticky_cleared", int'(if0.drop_sticky), 0);
`endif

        // Reset in HOLD with two queued requests
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        settle();
        chk_val("t5_pending2", int'(if0.pending), 2);
        cyc(1'b1, 1'b0, 1'b0);
        settle();
        chk_val("t5_sig_rst", int'(if0.sig), 0);
        chk_val("t5_pend_rst", int'(if0.pending), 0);
        chk_val("t5_busy_rst", int'(if0.busy), 0);
        cyc(1'b0, 1'b1, 1'b0);
        settle();
        chk_val("t5_latency1", int'(if0.sig), 1);

        // Random loopback: detected events equal accepted requests
        cyc(1'b1, 1'b0, 1'b0);
        settle();
        ev_s = ev0;
        dr_s = dr0;
        md_s = m_drops0;
        reqs = 0;
        while (reqs < 1000) begin
            rq  = ($urandom_range(0, 99) < 40);
            clr = ($urandom_range(0, 15) == 0);
            cyc(1'b0, rq, clr);
            if (rq) reqs++;
        end
        repeat (40) cyc(1'b0, 1'b0, 1'b0);
        settle();
        chk_val("t6_events", ev0 - ev_s, reqs - (m_drops0 - md_s));
        chk_val("t6_drop_pulses", dr0 - dr_s, m_drops0 - md_s);
        chk_val("t4_minhold1_no_drop", dr1, 0);
        chk_val("scoreboard_drained", q0.size() + q1.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
